// File: rtl/fd_latch_ctrl.sv
// Fetch-to-Decode latch sequencer: load/valid generation, fetch back-pressure,
// flush bubble insertion, exception hold, and saturating stall/flush counters.
module fd_latch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             f_valid,
  input  logic             f_ie,
  input  logic             d_stall,
  input  logic             flush_br,
  input  logic             flush_exc,
  input  logic             exc_ack,
  output logic             latch_ld,
  output logic             latch_valid_wr,
  output logic             f_stall,
  output logic             latch_occ,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    FLUSH    = 2'd2,
    EXC_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [3:0]       flush_ctr_r, flush_ctr_nxt_s;
  logic             latch_occ_r;
  logic [CNT_W-1:0] stall_cycles_r, flush_cnt_r;
  logic             flush_s, hold_s, stall_inc_s, flush_inc_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Next-state, flush countdown and zero-latency latch/fetch controls
  always_comb begin
    flush_s         = flush_br | flush_exc;
    hold_s          = 1'b0;
    latch_ld        = 1'b1;
    latch_valid_wr  = 1'b0;
    f_stall         = 1'b1;
    state_nxt_s     = state_r;
    flush_ctr_nxt_s = flush_ctr_r;
    stall_inc_s     = 1'b0;
    flush_inc_s     = 1'b0;
    if (clr) begin
      state_nxt_s = RUN;
    end else if (flush_s) begin
      state_nxt_s     = FLUSH;
      flush_ctr_nxt_s = FLUSH_LOAD;
      flush_inc_s     = 1'b1;
    end else begin
      case (state_r)
        RUN, STALL: begin
          // STALL is only entered with the latch occupied, so d_stall alone holds it
          hold_s = (state_r == RUN) ? (latch_occ_r & d_stall) : d_stall;
          if (hold_s) begin
            latch_ld    = 1'b0;
            state_nxt_s = STALL;
            stall_inc_s = 1'b1;
          end else begin
            latch_valid_wr = f_valid;
            f_stall        = 1'b0;
            state_nxt_s    = (f_valid & f_ie) ? EXC_WAIT : RUN;
          end
        end
        FLUSH: begin
          if (flush_ctr_r == 4'd0) begin
            state_nxt_s = RUN;
          end else begin
            flush_ctr_nxt_s = flush_ctr_r - 4'd1;
          end
        end
        EXC_WAIT: begin
          if (latch_occ_r & d_stall) begin
            latch_ld = 1'b0;
          end else begin
            latch_ld = 1'b1;
          end
          state_nxt_s = exc_ack ? RUN : EXC_WAIT;
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // State, latch occupancy and performance counter registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r        <= RUN;
      flush_ctr_r    <= 4'd0;
      latch_occ_r    <= 1'b0;
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      flush_ctr_r <= flush_ctr_nxt_s;
      if (latch_ld) begin
        latch_occ_r <= latch_valid_wr;
      end
      if (stall_inc_s) begin
        stall_cycles_r <= sat_inc(stall_cycles_r);
      end
      if (flush_inc_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign state        = state_r;
  assign latch_occ    = latch_occ_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: doc/fd_latch_ctrl.md
Name: fd_latch_ctrl

Overview:
- Sequencing controller for the Fetch-to-Decode pipeline latch.
- Generates the latch load enable and the valid bit written into the latch, back-pressures fetch, and squashes bubbles on branch mispredict and exception flushes.
- Holds fetch after an exception-tagged packet enters the latch until a downstream stage acknowledges it.
- Sits between the fetch stage, the F/D latch and the decode/writeback flush logic; keeps stall and flush performance counters.

Parameters:
FLUSH_CYCLES, 2, bubble cycles inserted per flush; legal range 1..15
CNT_W, 16, width of the saturating performance counters

Ports:
clk  input  1  clock
clr  input  1  synchronous, active-high reset
f_valid  input  1  fetch presents a valid packet this cycle
f_ie  input  1  the presented fetch packet carries an exception (IE)
d_stall  input  1  decode cannot consume the latch contents this cycle
flush_br  input  1  branch mispredict flush request
flush_exc  input  1  exception/interrupt flush request
exc_ack  input  1  downstream has taken the exception; fetch may resume
latch_ld  output  1  load enable to the F/D latch
latch_valid_wr  output  1  valid bit written into the latch when latch_ld=1
f_stall  output  1  fetch must hold its current packet
latch_occ  output  1  mirror of the latch valid bit
state  output  2  RUN=0, STALL=1, FLUSH=2, EXC_WAIT=3
stall_cycles  output  CNT_W  saturating count of d_stall hold cycles
flush_cnt  output  CNT_W  saturating count of accepted flush events

Behaviour:
- Storage and output timing:
  - state, latch_occ, the flush down-counter (4 bits) and both perf counters are registered.
  - latch_ld, latch_valid_wr and f_stall are combinational from the current state and inputs, with zero latency.
- Reset (clr=1 at a clock edge):
  - Next state=RUN, latch_occ=0, flush counter=0, stall_cycles=0, flush_cnt=0.
  - While clr=1, outputs are forced to latch_ld=1, latch_valid_wr=0, f_stall=1, so the latch is written invalid.
  - Reset mid-FLUSH or mid-EXC_WAIT abandons that state immediately.
- flush = flush_br | flush_exc. Priority: clr > flush > d_stall > normal load.
- Any state with flush=1:
  - latch_ld=1, latch_valid_wr=0, f_stall=1.
  - Next state=FLUSH; flush counter loads FLUSH_CYCLES-1.
  - flush_cnt increments by 1 (flush_br and flush_exc together count once).
- RUN (no flush):
  - If latch_occ & d_stall: latch_ld=0, f_stall=1, next state=STALL, stall_cycles increments.
  - Otherwise: latch_ld=1, latch_valid_wr=f_valid, f_stall=0.
  - If f_valid & f_ie, next state=EXC_WAIT; otherwise next state=RUN.
- STALL (no flush):
  - If d_stall: hold; latch_ld=0, f_stall=1, stall_cycles increments.
  - Otherwise: load exactly as in RUN, and next state is RUN or EXC_WAIT by the same rule.
- FLUSH (no new flush):
  - latch_ld=1, latch_valid_wr=0, f_stall=1; d_stall is ignored because the latch holds a bubble.
  - If the counter is 0, next state=RUN; otherwise the counter decrements.
  - A new flush reloads the counter.
  - With FLUSH_CYCLES=1, the machine is in FLUSH for exactly one cycle.
- EXC_WAIT (no flush):
  - f_stall=1.
  - If latch_occ & d_stall: latch_ld=0. Otherwise latch_ld=1 with latch_valid_wr=0, so the exception packet drains to decode and is followed by bubbles.
  - If exc_ack=1, next state=RUN (fetch resumes the following cycle).
  - exc_ack is ignored in all other states.
- latch_occ update:
  - latch_ld=1 → latch_occ becomes latch_valid_wr.
  - Otherwise latch_occ holds.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - They are cleared only by clr.
- Invariants:
  - f_stall=0 implies latch_ld=1.
  - latch_valid_wr=1 implies f_valid=1 and state is RUN or STALL.

Test Plan:
- Reset: hold clr 2 cycles with f_valid=1 → latch_ld=1, latch_valid_wr=0, f_stall=1; after release state=RUN, latch_occ=0, both counters=0.
- Stall: load one valid packet, then d_stall=1 for 3 cycles → latch_ld=0 and f_stall=1 for 3 cycles, state=STALL, stall_cycles=3. Release d_stall → latch_ld=1, state=RUN.
- Branch flush, FLUSH_CYCLES=2: flush_br pulse in RUN with f_valid=1 → latch_valid_wr=0 on the flush cycle plus 2 FLUSH cycles, f_stall=1 throughout, then RUN; flush_cnt=1, latch_occ=0.
- Back-to-back flush: flush_br, then flush_exc one cycle later → counter reloads, 3 total bubble cycles after the first flush, flush_cnt=2.
- Exception: f_valid=1, f_ie=1 in RUN → packet loaded with valid=1, state=EXC_WAIT. The next cycle loads valid=0. exc_ack after 5 cycles → RUN; f_stall high for all 5 cycles.
- Saturation, CNT_W=4: d_stall held 20 cycles with the latch occupied → stall_cycles stops at 15; reset mid-STALL → state=RUN, stall_cycles=0.
